// File: rtl/ram_8_bist.sv
// ram_8_bist: march-style self-test master for one ram_8 (write pattern, read back, repeat inverted)
module ram_8_bist #(
    parameter int WIDTH  = 16,
    parameter int PASSES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] mem_out,
    output logic [WIDTH-1:0] mem_in,
    output logic [2:0]       mem_addr,
    output logic             mem_load,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic             pass,
    output logic [2:0]       fail_addr,
    output logic [WIDTH-1:0] fail_data
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
    localparam logic K_LAST = 1'(PASSES - 1);
    state_t           state, state_nx;
    logic [2:0]       a, a_nx;
    logic             k, k_nx;
    logic [WIDTH-1:0] pat, exp_w;
    logic             mismatch, last_read;
    // fixed per-address pattern; the inverted pass flips every bit
    always_comb begin
        pat = '0;
        case (a)
            3'd0: pat = WIDTH'(16'h0000);
            3'd1: pat = WIDTH'(16'hFFFF);
            3'd2: pat = WIDTH'(16'h00FF);
            3'd3: pat = WIDTH'(16'hFF00);
            3'd4: pat = WIDTH'(16'h0F0F);
            3'd5: pat = WIDTH'(16'hF0F0);
            3'd6: pat = WIDTH'(16'h3333);
            default: pat = WIDTH'(16'hCCCC);
        endcase
        exp_w     = k ? ~pat : pat;
        mismatch  = mem_out != exp_w;
        last_read = (a == 3'd7) && (k == K_LAST);
    end
    // next-state logic and Moore outputs toward the RAM
    always_comb begin
        state_nx = state;
        a_nx     = a;
        k_nx     = k;
        case (state)
            IDLE: if (start) begin
                state_nx = WRITE;
                a_nx     = '0;
                k_nx     = 1'b0;
            end
            WRITE: begin
                a_nx = a + 3'd1;
                if (a == 3'd7) state_nx = READ;
            end
            READ: if (mismatch) state_nx = DONE;
            else begin
                a_nx = a + 3'd1;
                if (last_read) state_nx = DONE;
                else if (a == 3'd7) begin
                    state_nx = WRITE;
                    k_nx     = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        mem_load = state == WRITE;
        mem_in   = state == WRITE ? exp_w : '0;
        busy     = state == WRITE || state == READ;
        mem_addr = busy ? a : 3'd0;
        done     = state == DONE;
    end
    // control state; reset drops mem_load immediately via state=IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            a     <= '0;
            k     <= 1'b0;
        end else begin
            state <= state_nx;
            a     <= a_nx;
            k     <= k_nx;
        end
    end
    // result registers: cleared on an accepted start, captured on the way into DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid     <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (state == IDLE && start) begin
            valid     <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (state == READ && mismatch) begin
            valid     <= 1'b1;
            pass      <= 1'b0;
            fail_addr <= a;
            fail_data <= mem_out;
        end else if (state == READ && last_read) begin
            valid <= 1'b1;
            pass  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ram_8_bist.sv
// tb_ram_8_bist: directed checks of the BIST master against fault-injectable RAM models
module tb_ram_8_bist;
    logic        clk = 1'b0, reset = 1'b1, start0 = 1'b0, start1 = 1'b0;
    logic [15:0] out0, in0, out1, in1, fd0, fd1;
    logic [2:0]  addr0, addr1, fa0, fa1;
    logic        load0, busy0, done0, valid0, pass0;
    logic        load1, busy1, done1, valid1, pass1;
    logic        fault0 = 1'b0, fault1 = 1'b0;
    logic [15:0] m0 [8];
    logic [15:0] m1 [8];
    int          n_vec = 0, n_err = 0;
    int          cyc, busy_n, load_err;

    always #5 clk = ~clk;

    ram_8_bist #(.WIDTH(16), .PASSES(2)) u0 (
        .clk(clk), .reset(reset), .start(start0), .mem_out(out0), .mem_in(in0),
        .mem_addr(addr0), .mem_load(load0), .busy(busy0), .done(done0), .valid(valid0),
        .pass(pass0), .fail_addr(fa0), .fail_data(fd0));

    ram_8_bist #(.WIDTH(16), .PASSES(1)) u1 (
        .clk(clk), .reset(reset), .start(start1), .mem_out(out1), .mem_in(in1),
        .mem_addr(addr1), .mem_load(load1), .busy(busy1), .done(done1), .valid(valid1),
        .pass(pass1), .fail_addr(fa1), .fail_data(fd1));

    // ram_8 models: u0 side can stick bit 0 of word 5 low, u1 side can alias writes of 6 into 2
    always_ff @(posedge clk) begin
        if (load0) m0[addr0] <= in0;
        if (load1) m1[addr1] <= in1;
        if (load1 && fault1 && addr1 == 3'd6) m1[2] <= in1;
    end
    assign out0 = (fault0 && addr0 == 3'd5) ? (m0[5] & 16'hFFFE) : m0[addr0];
    assign out1 = m1[addr1];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic pulse(input bit sel);
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        tick;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // called in cycle 1 of a run; returns the cycle in which done is seen
    task automatic wait_done(input bit sel, input bit noise);
        cyc = 1;
        busy_n = 0;
        load_err = 0;
        while (!(sel ? done1 : done0) && cyc < 200) begin
            busy_n += int'(sel ? busy1 : busy0);
            if ((sel ? load1 : load0) !== ((cyc <= 8) || (cyc >= 17 && cyc <= 24))) load_err++;
            if (noise) start0 = (cyc == 3 || cyc == 20);
            tick;
            cyc++;
        end
        start0 = 1'b0;
    endtask

    initial begin
        tick;
        tick;
        chk("rst_mem_in", 32'(in0), 0);
        chk("rst_mem_addr", 32'(addr0), 0);
        chk("rst_mem_load", 32'(load0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_valid", 32'(valid0), 0);
        chk("rst_pass", 32'(pass0), 0);
        chk("rst_fail_addr", 32'(fa0), 0);
        chk("rst_fail_data", 32'(fd0), 0);
        reset = 1'b0;
        tick;
        // reset in cycle 4 of the write phase
        pulse(0);
        tick;
        tick;
        tick;
        chk("midrun_load_before", 32'(load0), 1);
        chk("midrun_addr_before", 32'(addr0), 3);
        chk("midrun_data_before", 32'(in0), 32'h0000FF00);
        reset = 1'b1;
        #1;
        chk("midrun_load", 32'(load0), 0);
        chk("midrun_busy", 32'(busy0), 0);
        chk("midrun_done", 32'(done0), 0);
        chk("midrun_valid", 32'(valid0), 0);
        chk("midrun_pass", 32'(pass0), 0);
        tick;
        reset = 1'b0;
        tick;
        // clean run, two passes
        pulse(0);
        chk("clean_valid_cleared", 32'(valid0), 0);
        wait_done(0, 0);
        chk("clean_done_cycle", 32'(cyc), 33);
        chk("clean_busy_cycles", 32'(busy_n), 32);
        chk("clean_load_pattern", 32'(load_err), 0);
        chk("clean_pass", 32'(pass0), 1);
        chk("clean_valid", 32'(valid0), 1);
        chk("clean_fail_addr", 32'(fa0), 0);
        chk("clean_fail_data", 32'(fd0), 0);
        chk("clean_ram1", 32'(m0[1]), 32'h0000);
        chk("clean_ram7", 32'(m0[7]), 32'h3333);
        chk("clean_ram4", 32'(m0[4]), 32'hF0F0);
        tick;
        chk("after_done_low", 32'(done0), 0);
        chk("after_valid_hold", 32'(valid0), 1);
        chk("after_pass_hold", 32'(pass0), 1);
        // starts during a run are ignored
        pulse(0);
        wait_done(0, 1);
        chk("ignore_done_cycle", 32'(cyc), 33);
        chk("ignore_busy_cycles", 32'(busy_n), 32);
        chk("ignore_load_pattern", 32'(load_err), 0);
        chk("ignore_pass", 32'(pass0), 1);
        tick;
        pulse(0);
        chk("restart_valid_cleared", 32'(valid0), 0);
        chk("restart_pass_cleared", 32'(pass0), 0);
        chk("restart_busy", 32'(busy0), 1);
        wait_done(0, 0);
        chk("restart_done_cycle", 32'(cyc), 33);
        tick;
        // stuck-at-0 on bit 0 of word 5: only the inverted pass sees it
        fault0 = 1'b1;
        pulse(0);
        wait_done(0, 0);
        chk("stuck_done_cycle", 32'(cyc), 31);
        chk("stuck_pass", 32'(pass0), 0);
        chk("stuck_valid", 32'(valid0), 1);
        chk("stuck_fail_addr", 32'(fa0), 5);
        chk("stuck_fail_data", 32'(fd0), 32'h0F0E);
        tick;
        chk("stuck_hold_addr", 32'(fa0), 5);
        // single pass, address 6 aliases onto 2
        fault1 = 1'b1;
        pulse(1);
        wait_done(1, 0);
        chk("alias_done_cycle", 32'(cyc), 12);
        chk("alias_pass", 32'(pass1), 0);
        chk("alias_fail_addr", 32'(fa1), 2);
        chk("alias_fail_data", 32'(fd1), 32'h3333);
        tick;
        // clean single pass clears stale failure info
        fault1 = 1'b0;
        pulse(1);
        chk("p1_fail_addr_cleared", 32'(fa1), 0);
        wait_done(1, 0);
        chk("p1_done_cycle", 32'(cyc), 17);
        chk("p1_busy_cycles", 32'(busy_n), 16);
        chk("p1_pass", 32'(pass1), 1);
        chk("p1_fail_data", 32'(fd1), 0);
        // start held high restarts right after DONE
        start1 = 1'b1;
        tick;
        chk("held_idle_busy", 32'(busy1), 0);
        tick;
        chk("held_restart_busy", 32'(busy1), 1);
        chk("held_restart_load", 32'(load1), 1);
        start1 = 1'b0;
        wait_done(1, 0);
        chk("held_done_cycle", 32'(cyc), 17);
        chk("held_pass", 32'(pass1), 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ram_8_bist.md
Name: ram_8_bist

Overview:
- Built-in self-test initiator for one ram_8 instance; drives the RAM's in/addr/load inputs and checks its out.
- On start, writes a fixed 8-word pattern to all addresses and reads each back, then repeats with the bitwise-inverted pattern.
- Reports pass/fail, plus the first failing address and the data read there.
- Sits beside ram_8 in the memory hierarchy as its test master; the mem_* ports connect port-for-port to ram_8.

Parameters:
- WIDTH, 16, data width; only 16 is supported because the pattern table is 16-bit.
- PASSES, 2, number of write/read passes; 1 = true pattern only, 2 = true then inverted.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a test run; sampled only in IDLE.
- mem_out  input  WIDTH  ram_8 out (combinational read of word at mem_addr).
- mem_in  output  WIDTH  write data to ram_8 in.
- mem_addr  output  3  address to ram_8 addr.
- mem_load  output  1  write enable to ram_8 load.
- busy  output  1  high while a run is in progress.
- done  output  1  single-cycle pulse when a run ends (pass or fail).
- valid  output  1  result outputs hold a completed run's result.
- pass  output  1  1 = last run matched at every address.
- fail_addr  output  3  address of first mismatch.
- fail_data  output  WIDTH  mem_out value captured at first mismatch.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-high.
- Reset (async, immediate): state=IDLE; mem_in=0, mem_addr=0, mem_load=0, busy=0, done=0, valid=0, pass=0, fail_addr=0, fail_data=0.
  - Reset mid-run aborts the run, deasserts mem_load at once and leaves RAM contents undefined.
- Pattern P[a], a=0..7: 0000, FFFF, 00FF, FF00, 0F0F, F0F0, 3333, CCCC (hex).
  - Pass k expects E[a] = P[a] when k=0, and ~P[a] when k=1.
- States: IDLE, WRITE, READ, DONE. Address counter a (3-bit), pass counter k.
- IDLE:
  - Outputs mem_load=0, mem_in=0, busy=0.
  - start=1 at an edge → WRITE with a=0, k=0; busy=1; valid=0 and pass=0 cleared.
  - start while busy or in DONE is ignored.
- WRITE: mem_addr=a, mem_in=E[a], mem_load=1 for exactly one cycle per address.
  - a=7 → READ with a=0; otherwise a+1.
- READ: mem_addr=a, mem_load=0, mem_in=0. At the edge ending the cycle, compare mem_out against E[a].
  - Mismatch → fail_addr=a, fail_data=mem_out, pass=0, go to DONE (first failure aborts the run).
  - Match, a<7 → a+1.
  - Match, a=7, k<PASSES-1 → WRITE with k+1, a=0.
  - Match, a=7, final pass → pass=1, DONE.
- DONE (one cycle):
  - done=1, valid=1, busy=0, mem_load=0, then → IDLE.
  - Result outputs hold until the next accepted start or reset.
- Latency, start sampled at edge E0:
  - Clean run with PASSES=2: busy high for 32 cycles (8 write + 8 read per pass); done high in cycle 33.
  - Failure at read of address a in pass k: done is high 16k+8+a+2 cycles after E0.
- mem_load is never high outside WRITE; mem_addr wraps 7→0 only at a phase change.
- fail_addr and fail_data stay 0 on a passing run.
- start held high continuously starts a new run in the cycle after each DONE.

Test Plan:
- Reset mid-WRITE at cycle 4: assert reset → mem_load, busy, done, valid, pass all 0 immediately.
  - Then release reset and pulse start → a full clean run completes.
- Clean run, PASSES=2, real ram_8 attached: pulse start → mem_load high in cycles 1-8 and 17-24.
  - done in cycle 33, pass=1, valid=1, fail_addr=0.
  - RAM finally holds the inverted pattern: addr 1 reads 0000, addr 7 reads 3333.
- Stuck-at fault model: ram_8 wrapper forces bit 0 of word 5 to 0, PASSES=2.
  - First pass passes (F0F0 has bit 0 clear).
  - Inverted pass fails at addr 5: pass=0, fail_addr=5, fail_data=0F0E, done in cycle 16+8+5+2=31.
- Address-aliasing model: writes to 6 also land in 2, PASSES=1.
  - Read of addr 2 returns 3333 → fail_addr=2, fail_data=3333, done 12 cycles after start.
- Ignored start: pulse start in cycles 3 and 20 of a run → no restart, same timing as a clean run.
  - After done, a new start clears valid the following cycle and runs again.
